// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 encodings and the burst master's FSM state type.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

endpackage

// File: rtl/wb_b3_burst_master_if.sv
// Wishbone B3 bus bundle between one initiator and the slave fabric.
interface wb_b3_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0] wb_adr_o;
  logic [dw-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o;
  logic [1:0]    wb_bte_o;
  logic [2:0]    wb_cti_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [dw-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_b3_adr_next.sv
// Next word address of a Wishbone burst: linear increment or 4/8/16-beat wrap.
module wb_b3_adr_next
  import wb_b3_pkg::*;
#(
  parameter int aw = 32
) (
  input  logic [aw-3:0] word_adr,
  input  logic [1:0]    bte,
  output logic [aw-3:0] next_adr
);

  logic [aw-3:0] inc;
  logic [aw-3:0] mask;

  // Only the masked low bits take the incremented value; the rest hold.
  always_comb begin
    inc  = word_adr + (aw-2)'(1);
    mask = '1;
    case (bte)
      BTE_LINEAR: mask = '1;
      BTE_WRAP4:  mask = (aw-2)'(4'h3);
      BTE_WRAP8:  mask = (aw-2)'(4'h7);
      BTE_WRAP16: mask = (aw-2)'(4'hf);
    endcase
    next_adr = (word_adr & ~mask) | (inc & mask);
  end

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst initiator: one command becomes one registered-feedback burst.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int len_w = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  // Handshakes: cmd is taken on a cycle with cmd_valid_i & cmd_ready_o; a write
  // beat is taken on a cycle with wr_valid_i & wr_ready_o; rd_valid_o has no ready.
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [aw-1:0]    cmd_adr_i,
  input  logic [len_w-1:0] cmd_len_i,
  input  logic [1:0]       cmd_bte_i,
  input  logic [dw-1:0]    wr_dat_i,
  input  logic [3:0]       wr_sel_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [dw-1:0]    rd_dat_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic             err_o,
  output state_t           state_o,
  wb_b3_burst_master_if.master wb
);

  localparam logic [len_w:0]  REM_ONE  = (len_w+1)'(1);
  localparam logic [len_w:0]  REM_TWO  = (len_w+1)'(2);
  localparam logic [aw-1:0]   WORD_MSK = ~(aw'(3));

  state_t          state;
  logic [aw-1:0]   adr_r;
  logic            we_r;
  logic [1:0]      bte_r;
  logic [2:0]      cti_r;
  logic            cyc_r;
  logic            stb_r;
  logic [len_w:0]  remaining;
  logic [aw-3:0]   adr_nxt;
  logic            stb_gated;
  logic            bus_live;
  logic            bus_err;
  logic            bus_ack;

  wb_b3_adr_next #(.aw(aw)) u_adr_next (
    .word_adr (adr_r[aw-1:2]),
    .bte      (bte_r),
    .next_adr (adr_nxt)
  );

  // A write beat only strobes while its data is present; cyc holds across the gap.
  assign stb_gated = stb_r & (~we_r | wr_valid_i);
  assign bus_live  = (state == ST_BUS) & cyc_r & stb_gated;
  assign bus_err   = bus_live & (wb.wb_err_i | wb.wb_rty_i);
  assign bus_ack   = bus_live & wb.wb_ack_i & ~(wb.wb_err_i | wb.wb_rty_i);

  assign cmd_ready_o = (state == ST_IDLE);
  assign wr_ready_o  = we_r & bus_ack;
  assign state_o     = state;

  assign wb.wb_adr_o = adr_r;
  assign wb.wb_dat_o = wr_dat_i;
  assign wb.wb_sel_o = we_r ? wr_sel_i : 4'hf;
  assign wb.wb_we_o  = we_r;
  assign wb.wb_bte_o = bte_r;
  assign wb.wb_cti_o = cti_r;
  assign wb.wb_cyc_o = cyc_r;
  assign wb.wb_stb_o = stb_gated;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      adr_r      <= '0;
      we_r       <= 1'b0;
      bte_r      <= BTE_LINEAR;
      cti_r      <= CTI_CLASSIC;
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      remaining  <= '0;
      rd_dat_o   <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            state     <= ST_BUS;
            adr_r     <= cmd_adr_i & WORD_MSK;
            we_r      <= cmd_we_i;
            bte_r     <= cmd_bte_i;
            remaining <= (len_w+1)'(cmd_len_i) + REM_ONE;
            cti_r     <= (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INC;
            cyc_r     <= 1'b1;
            stb_r     <= 1'b1;
          end
        end
        ST_BUS: begin
          if (bus_err) begin
            state <= ST_IDLE;
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            err_o <= 1'b1;
          end else if (bus_ack) begin
            remaining     <= remaining - REM_ONE;
            adr_r[aw-1:2] <= adr_nxt;
            if (!we_r) begin
              rd_dat_o   <= wb.wb_dat_i;
              rd_valid_o <= 1'b1;
            end
            if (remaining == REM_ONE) begin
              state  <= ST_IDLE;
              cyc_r  <= 1'b0;
              stb_r  <= 1'b0;
              done_o <= 1'b1;
            end else if (remaining == REM_TWO) begin
              cti_r <= CTI_EOB;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Bench for wb_b3_burst_master: table of burst commands against a RAM slave, plus corner sequences.
`timescale 1ns/1ps
module tb_wb_b3_burst_master;
  import wb_b3_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we    = 1'b0;
  logic [31:0] cmd_adr   = '0;
  logic [3:0]  cmd_len   = '0;
  logic [1:0]  cmd_bte   = '0;
  logic [31:0] wr_dat    = '0;
  logic [3:0]  wr_sel    = '0;
  logic        wr_valid  = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_dat;
  logic        rd_valid;
  logic        done;
  logic        err;
  state_t      dbg_state;

  wb_b3_burst_master_if #(.dw(32), .aw(32)) bus ();

  wb_b3_burst_master #(.dw(32), .aw(32), .len_w(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_len_i   (cmd_len),
    .cmd_bte_i   (cmd_bte),
    .wr_dat_i    (wr_dat),
    .wr_sel_i    (wr_sel),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .rd_dat_o    (rd_dat),
    .rd_valid_o  (rd_valid),
    .done_o      (done),
    .err_o       (err),
    .state_o     (dbg_state),
    .wb          (bus.master)
  );

  // ---------------- RAM slave (combinational ack, optional error beat) ----------------
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        err_now = 1'b0;
  int          err_at  = -1;

  assign bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o & ~err_now;
  assign bus.wb_err_i = bus.wb_cyc_o & bus.wb_stb_o & err_now;
  assign bus.wb_rty_i = 1'b0;
  assign bus.wb_dat_i = mem[bus.wb_adr_o[9:2]];

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt, rd_cnt, done_cnt, err_cnt;
  bit          pop_pending = 1'b0;
  logic [31:0] exp_q   [$];
  logic [35:0] wr_q    [$];
  logic [31:0] obs_adr [$];
  logic [2:0]  obs_cti [$];
  logic        obs_we  [$];
  logic [31:0] obs_dat [$];
  logic [3:0]  obs_sel [$];
  logic [1:0]  obs_bte [$];
  logic [31:0] mon_exp;
  logic [35:0] wr_drop;
  logic [7:0]  mon_widx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: expected event did not occur within its bound", nm);
  endtask

  // Monitor samples mid-cycle; bench inputs only change just after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
        obs_adr.push_back(bus.wb_adr_o);
        obs_cti.push_back(bus.wb_cti_o);
        obs_we.push_back(bus.wb_we_o);
        obs_dat.push_back(bus.wb_dat_o);
        obs_sel.push_back(bus.wb_sel_o);
        obs_bte.push_back(bus.wb_bte_o);
        if (bus.wb_we_o) begin
          mon_widx = bus.wb_adr_o[9:2];
          for (int b = 0; b < 4; b++)
            if (bus.wb_sel_o[b]) mem[mon_widx][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
        end
      end
      if (wr_ready) begin
        wr_cnt++;
        pop_pending = 1'b1;
      end
      if (rd_valid) begin
        rd_cnt++;
        if (exp_q.size() == 0) fail_now("rd_valid with no read expected");
        else begin
          mon_exp = exp_q.pop_front();
          check("rd_dat", rd_dat, mon_exp);
        end
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  // Write-stream source and slave error injection, updated after the driver each cycle.
  always @(posedge clk) begin
    #2;
    if (pop_pending && wr_q.size() > 0) wr_drop = wr_q.pop_front();
    pop_pending = 1'b0;
    wr_valid = (wr_q.size() > 0);
    if (wr_q.size() > 0) begin
      wr_dat = wr_q[0][31:0];
      wr_sel = wr_q[0][35:32];
    end
    err_now = (err_at >= 0) && (obs_adr.size() == err_at);
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  len;
    logic [1:0]  bte;
    logic [31:0] dat0;
    logic [3:0]  sel;
    logic [31:0] exp_adr [8];
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  function automatic vec_t mk(input string n, input logic we, input logic [31:0] adr,
                              input logic [3:0] len, input logic [1:0] bte,
                              input logic [31:0] dat0, input logic [3:0] sel,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [31:0] a4, input logic [31:0] a5,
                              input logic [31:0] a6, input logic [31:0] a7);
    vec_t v;
    v.name = n; v.we = we; v.adr = adr; v.len = len; v.bte = bte; v.dat0 = dat0; v.sel = sel;
    v.exp_adr[0] = a0; v.exp_adr[1] = a1; v.exp_adr[2] = a2; v.exp_adr[3] = a3;
    v.exp_adr[4] = a4; v.exp_adr[5] = a5; v.exp_adr[6] = a6; v.exp_adr[7] = a7;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_adr.delete(); obs_cti.delete(); obs_we.delete();
    obs_dat.delete(); obs_sel.delete(); obs_bte.delete();
    exp_q.delete(); wr_q.delete();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  // Called at posedge+1; the command is accepted on the following posedge.
  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                           input logic [1:0] bte);
    check("cmd_ready before issue", 32'(cmd_ready), 32'd1);
    cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm, input logic expect_err);
    int t = 0;
    while (!(done || err) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail_now({nm, " end of command"});
    else begin
      check({nm, " done_o"}, 32'(done), 32'(!expect_err));
      check({nm, " err_o"}, 32'(err), 32'(expect_err));
      check({nm, " cyc after end"}, 32'(bus.wb_cyc_o), 32'd0);
      check({nm, " stb after end"}, 32'(bus.wb_stb_o), 32'd0);
      check({nm, " cmd_ready after end"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic load_expect(input vec_t v);
    logic [7:0]  w;
    logic [31:0] d;
    for (int k = 0; k <= int'(v.len); k++) begin
      w = v.exp_adr[k][9:2];
      if (v.we) begin
        d = v.dat0 + 32'(k);
        wr_q.push_back({v.sel, d});
        for (int b = 0; b < 4; b++)
          if (v.sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back(ref_mem[w]);
      end
    end
  endtask

  task automatic check_beats(input vec_t v, input int nb);
    logic [2:0] ecti;
    logic [7:0] w;
    check({v.name, " beat count"}, 32'(obs_adr.size()), 32'(nb));
    for (int k = 0; k < nb && k < obs_adr.size(); k++) begin
      if (k == nb - 1) ecti = (nb == 1) ? CTI_CLASSIC : CTI_EOB;
      else             ecti = CTI_INC;
      check($sformatf("%s beat%0d adr", v.name, k), obs_adr[k], v.exp_adr[k]);
      check($sformatf("%s beat%0d cti", v.name, k), 32'(obs_cti[k]), 32'(ecti));
      check($sformatf("%s beat%0d we", v.name, k), 32'(obs_we[k]), 32'(v.we));
      if (k == 0) check({v.name, " bte"}, 32'(obs_bte[k]), 32'(v.bte));
      if (v.we) begin
        check($sformatf("%s beat%0d wdat", v.name, k), obs_dat[k], v.dat0 + 32'(k));
        check($sformatf("%s beat%0d sel", v.name, k), 32'(obs_sel[k]), 32'(v.sel));
      end else begin
        check($sformatf("%s beat%0d sel", v.name, k), 32'(obs_sel[k]), 32'hf);
      end
    end
    if (v.we) begin
      check({v.name, " wr_ready count"}, 32'(wr_cnt), 32'(nb));
      for (int k = 0; k < nb; k++) begin
        w = v.exp_adr[k][9:2];
        check($sformatf("%s ram word %0d", v.name, k), mem[w], ref_mem[w]);
      end
    end else begin
      check({v.name, " rd_valid count"}, 32'(rd_cnt), 32'(nb));
      check({v.name, " reads left"}, 32'(exp_q.size()), 32'd0);
    end
    check({v.name, " done count"}, 32'(done_cnt), 32'd1);
    check({v.name, " err count"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    clear_obs();
    load_expect(v);
    issue_cmd(v.we, v.adr, v.len, v.bte);
    wait_end(v.name, 1'b0);
    repeat (2) @(negedge clk);
    check_beats(v, int'(v.len) + 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t h;
    int   t;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[8'h40] = 32'hAAAA_0001;
    mem[8'h41] = 32'hBBBB_0002;
    mem[8'h42] = 32'hCCCC_0003;
    mem[8'h43] = 32'hDDDD_0004;
    mem[8'h80] = 32'h1234_5678;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    vecs[0] = mk("rd_lin",        1'b0, 32'h100, 4'd3, 2'b00, 0, 4'hf,
                 32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0);
    vecs[1] = mk("wr_wrap4",      1'b1, 32'h108, 4'd3, 2'b01, 32'h5100_0000, 4'hf,
                 32'h108, 32'h10C, 32'h100, 32'h104, 0, 0, 0, 0);
    vecs[2] = mk("rd_wrap4",      1'b0, 32'h108, 4'd3, 2'b01, 0, 4'hf,
                 32'h108, 32'h10C, 32'h100, 32'h104, 0, 0, 0, 0);
    vecs[3] = mk("wr_single",     1'b1, 32'h200, 4'd0, 2'b00, 32'hDEAD_BEEF, 4'b0011,
                 32'h200, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk("rd_wrap8",      1'b0, 32'h3F8, 4'd5, 2'b10, 0, 4'hf,
                 32'h3F8, 32'h3FC, 32'h3E0, 32'h3E4, 32'h3E8, 32'h3EC, 0, 0);
    vecs[5] = mk("rd_wrap4_long", 1'b0, 32'h10C, 4'd5, 2'b01, 0, 4'hf,
                 32'h10C, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 0, 0);
    vecs[6] = mk("rd_lin2",       1'b0, 32'h0FC, 4'd1, 2'b00, 0, 4'hf,
                 32'h0FC, 32'h100, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk("rd_wrap16",     1'b0, 32'h03E, 4'd4, 2'b11, 0, 4'hf,
                 32'h03C, 32'h000, 32'h004, 32'h008, 32'h00C, 0, 0, 0);

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("reset cyc", 32'(bus.wb_cyc_o), 32'd0);
    check("reset stb", 32'(bus.wb_stb_o), 32'd0);
    check("reset we", 32'(bus.wb_we_o), 32'd0);
    check("reset adr", bus.wb_adr_o, 32'd0);
    check("reset cti", 32'(bus.wb_cti_o), 32'd0);
    check("reset bte", 32'(bus.wb_bte_o), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);
    check("wr_wrap4 ram 0x108", mem[8'h42], 32'h5100_0000);
    check("wr_wrap4 ram 0x100", mem[8'h40], 32'h5100_0002);
    check("wr_single byte lanes", mem[8'h80], 32'h1234_BEEF);

    // Write stream stalls for three cycles after the second beat.
    h = mk("wr_stall", 1'b1, 32'h140, 4'd7, 2'b00, 32'h7700_0000, 4'hf,
           32'h140, 32'h144, 32'h148, 32'h14C, 32'h150, 32'h154, 32'h158, 32'h15C);
    @(posedge clk); #1;
    clear_obs();
    load_expect(h);
    repeat (6) wr_drop = wr_q.pop_back();
    issue_cmd(1'b1, 32'h140, 4'd7, 2'b00);
    t = 0;
    while (wr_cnt < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) fail_now("wr_stall first two beats");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("wr_stall gap%0d stb", c), 32'(bus.wb_stb_o), 32'd0);
      check($sformatf("wr_stall gap%0d cyc", c), 32'(bus.wb_cyc_o), 32'd1);
      check($sformatf("wr_stall gap%0d adr", c), bus.wb_adr_o, 32'h148);
      check($sformatf("wr_stall gap%0d cti", c), 32'(bus.wb_cti_o), 32'(CTI_INC));
    end
    @(posedge clk); #1;
    for (int k = 2; k < 8; k++) wr_q.push_back({4'hf, 32'h7700_0000 + 32'(k)});
    wait_end("wr_stall", 1'b0);
    repeat (2) @(negedge clk);
    check_beats(h, 8);

    // Read burst whose third beat is answered with an error.
    @(posedge clk); #1;
    clear_obs();
    err_at = 2;
    exp_q.push_back(ref_mem[0]);
    exp_q.push_back(ref_mem[1]);
    issue_cmd(1'b0, 32'h000, 4'd7, 2'b00);
    wait_end("rd_err", 1'b1);
    repeat (3) @(negedge clk);
    check("rd_err rd_valid count", 32'(rd_cnt), 32'd2);
    check("rd_err reads left", 32'(exp_q.size()), 32'd0);
    check("rd_err acked beats", 32'(obs_adr.size()), 32'd2);
    check("rd_err done count", 32'(done_cnt), 32'd0);
    check("rd_err err count", 32'(err_cnt), 32'd1);
    check("rd_err cmd_ready", 32'(cmd_ready), 32'd1);
    err_at = -1;

    // Asynchronous reset between clock edges in the middle of a read burst.
    @(posedge clk); #1;
    clear_obs();
    for (int k = 0; k < 8; k++) exp_q.push_back(ref_mem[k]);
    issue_cmd(1'b0, 32'h000, 4'd7, 2'b00);
    t = 0;
    while (obs_adr.size() < 3 && t < 50) begin
      @(posedge clk); #3;
      t++;
    end
    if (t >= 50) fail_now("rst_mid third beat");
    rst = 1'b1;
    #1;
    check("rst_mid cyc before edge", 32'(bus.wb_cyc_o), 32'd0);
    check("rst_mid stb before edge", 32'(bus.wb_stb_o), 32'd0);
    check("rst_mid rd_valid", 32'(rd_valid), 32'd0);
    #3;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid rd_valid count", 32'(rd_cnt), 32'd2);
    check("rst_mid done count", 32'(done_cnt), 32'd0);
    check("rst_mid err count", 32'(err_cnt), 32'd0);
    check("rst_mid cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid cyc", 32'(bus.wb_cyc_o), 32'd0);
    exp_q.delete();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
